serial_add_sub: RTL and testbench
=================================

# serial_add_sub

Parametrised digit-serial adder/subtractor. Successor to the fixed 4-bit ripple adder. Adds or subtracts two WIDTH-bit operands DIGIT bits per clock using one shared DIGIT-bit carry chain and a registered carry between digits. Uses a START/BUSY/DONE handshake, so datapaths can trade latency for area.

## Interface

Parameters:
- WIDTH, 16, operand and result width in bits; must be a multiple of DIGIT.
- DIGIT, 4, bits processed per clock; 1 ≤ DIGIT ≤ WIDTH. STEPS = WIDTH/DIGIT.

Ports:
- CLK  input  1  single clock; all state updates on rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- START  input  1  request; sampled only when BUSY=0.
- SUB  input  1  0: A+B+CIN; 1: A−B (A + ~B + 1, CIN ignored); sampled with START.
- A  input  WIDTH  operand A; sampled with START.
- B  input  WIDTH  operand B; sampled with START.
- CIN  input  1  carry in for add; sampled with START.
- BUSY  output  1  operation in progress.
- DONE  output  1  one-cycle pulse; result valid.
- SUM  output  WIDTH  registered result; holds its value until the next completion.
- COUT  output  1  final carry out; for SUB, 1 = no borrow (A ≥ B unsigned).
- OVF  output  1  two's-complement overflow of the completed operation.

## Operation

- FSM has two states: IDLE and RUN.
  - IDLE → RUN on START=1. On that edge, latch A into shift register a_sh, latch (SUB ? ~B : B) into b_sh, set carry = (SUB ? 1 : CIN), load step counter to 0, and latch the sign bits A[WIDTH-1] and b_eff[WIDTH-1].
- Each RUN cycle:
  - {c, d} = a_sh[DIGIT-1:0] + b_sh[DIGIT-1:0] + carry.
  - d is shifted into the top of the internal result register r_sh (LSB digit first).
  - a_sh and b_sh shift right by DIGIT; carry ← c; counter increments.
- When counter == STEPS−1 in RUN:
  - Next state is IDLE.
  - SUM ← completed r_sh and COUT ← c.
  - OVF computed (see Configuration).
  - DONE asserted for the following cycle.
- START is ignored while BUSY=1; no queuing.
- START in the cycle DONE is high is accepted (BUSY=0 in that cycle).
- SUM, COUT and OVF change only at completion. They hold the previous result throughout RUN.
- Arithmetic is modulo 2^WIDTH. COUT is the carry out of bit WIDTH−1.

## Timing

- START sampled high at edge t: BUSY=1 for cycles t+1 … t+STEPS.
- DONE=1 and BUSY=0 in cycle t+STEPS+1; SUM, COUT and OVF are valid from then on.
- Latency is STEPS+1 clocks from the START edge to DONE. Back-to-back throughput is one result per STEPS+1 clocks.
- DIGIT=WIDTH gives STEPS=1: one RUN cycle, DONE 2 cycles after START.
- Reset values (RST_N low, asynchronous): state IDLE; BUSY=0, DONE=0, SUM=0, COUT=0, OVF=0; internal registers 0.
- Reset asserted mid-operation aborts the operation immediately. No DONE is produced. After release the block idles until a new START.

## Configuration

- SERIAL_ADD_SUB_OVF_EN:
  - Defined: OVF = (a_sign == b_eff_sign) && (SUM[WIDTH-1] != a_sign), registered at completion alongside SUM.
  - Undefined: the overflow logic is omitted and OVF is tied to 0. All other behaviour is identical.

## Test plan

Use WIDTH=16, DIGIT=4 (STEPS=4) unless noted; OVF checks require SERIAL_ADD_SUB_OVF_EN.

- A=0x1234, B=0x4321, CIN=0, SUB=0 → BUSY high 4 cycles; DONE 5 cycles after START; SUM=0x5555, COUT=0, OVF=0.
- A=0xFFFF, B=0x0001, CIN=0 → SUM=0x0000, COUT=1, OVF=0. Same operands with CIN=1 → SUM=0x0001, COUT=1.
- A=0x7FFF, B=0x0001, SUB=0 → SUM=0x8000, OVF=1 (OVF=0 when macro undefined). A=0x8000, B=0x0001, SUB=1 → SUM=0x7FFF, COUT=1, OVF=1.
- A=0x0005, B=0x0007, SUB=1 → SUM=0xFFFE, COUT=0 (borrow). Repeat with DIGIT=1: DONE 17 cycles after START, same result.
- START pulsed again during BUSY with different operands → ignored; only the first result appears. START in the DONE cycle → accepted, next DONE 5 cycles later.
- RST_N dropped at cycle t+2 of an operation → BUSY, DONE, SUM, COUT, OVF all 0 immediately. After release, no DONE appears without a new START.

Source files
------------

// File: rtl/serial_add_sub_if.sv
// serial_add_sub_if: START/BUSY/DONE handshake and operand/result bus for
// the digit-serial adder/subtractor. The master side issues requests, the
// slave side (the arithmetic block) returns results.
interface serial_add_sub_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, sub, a, b, cin,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, sub, a, b, cin,
        output busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/serial_add_sub.sv
// serial_add_sub: digit-serial adder/subtractor. Processes DIGIT bits per
// clock through one shared DIGIT-bit carry chain with a registered carry
// between digits; WIDTH/DIGIT RUN cycles per operation, DONE one cycle later.
// Optional feature macro: SERIAL_ADD_SUB_OVF_EN enables the two's-complement
// overflow flag; when undefined OVF is tied to 0.
module serial_add_sub #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    serial_add_sub_if.slave bus
);
    localparam int STEPS = WIDTH / DIGIT;
    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic               w_load;
    logic               w_busy;
    logic               w_last;

    logic [WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]   r_b_sh;
    logic [WIDTH-1:0]   r_r_sh;
    logic               r_carry;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;
    logic               r_done;

    logic [WIDTH-1:0]   w_b_eff;
    logic [DIGIT:0]     w_digit_sum;
    logic [DIGIT-1:0]   w_d;
    logic               w_c;
    logic [WIDTH-1:0]   w_r_next;

    // Subtraction is A + ~B + 1: invert B on load, force carry-in to 1.
    assign w_b_eff     = bus.sub ? ~bus.b : bus.b;

    // Shared DIGIT-bit carry chain on the low digit of each shift register.
    assign w_digit_sum = {1'b0, r_a_sh[DIGIT-1:0]} + {1'b0, r_b_sh[DIGIT-1:0]}
                       + {{DIGIT{1'b0}}, r_carry};
    assign w_d         = w_digit_sum[DIGIT-1:0];
    assign w_c         = w_digit_sum[DIGIT];

    // New digit enters at the top, so after STEPS shifts the LSB digit
    // has walked down to bit 0 and r_r_sh holds the full result.
    assign w_r_next    = (r_r_sh >> DIGIT) | (WIDTH'(w_d) << (WIDTH - DIGIT));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next_state;
    end

    // Next-state and control decode; START only matters in IDLE.
    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_busy       = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_next_state = RUN;
                    w_load       = 1'b1;
                end
            end
            RUN: begin
                w_busy = 1'b1;
                if (r_cnt == CNT_W'(STEPS - 1)) begin
                    w_last       = 1'b1;
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Operand shift registers, digit carry and step counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_r_sh  <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
        end else if (w_load) begin
            r_a_sh  <= bus.a;
            r_b_sh  <= w_b_eff;
            r_carry <= bus.sub ? 1'b1 : bus.cin;
            r_cnt   <= '0;
        end else if (w_busy) begin
            r_a_sh  <= r_a_sh >> DIGIT;
            r_b_sh  <= r_b_sh >> DIGIT;
            r_r_sh  <= w_r_next;
            r_carry <= w_c;
            r_cnt   <= r_cnt + 1'b1;
        end
    end

    // Result registers update only at completion; DONE pulses one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum  <= '0;
            r_cout <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_last;
            if (w_last) begin
                r_sum  <= w_r_next;
                r_cout <= w_c;
            end
        end
    end

`ifdef SERIAL_ADD_SUB_OVF_EN
    logic r_a_sign;
    logic r_b_sign;
    logic r_ovf;

    // Overflow: operands of equal sign producing a result of the other sign.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sign <= 1'b0;
            r_b_sign <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_load) begin
                r_a_sign <= bus.a[WIDTH-1];
                r_b_sign <= w_b_eff[WIDTH-1];
            end
            if (w_last)
                r_ovf <= (r_a_sign == r_b_sign) && (w_r_next[WIDTH-1] != r_a_sign);
        end
    end

    assign bus.ovf = r_ovf;
`else
    assign bus.ovf = 1'b0;
`endif

    assign bus.busy = (r_state == RUN);
    assign bus.done = r_done;
    assign bus.sum  = r_sum;
    assign bus.cout = r_cout;
endmodule

// File: tb/tb_serial_add_sub.sv
// tb_serial_add_sub: directed checks of the digit-serial adder/subtractor
// with WIDTH=16 at DIGIT=4 (main instance) and DIGIT=1 (latency instance).
module tb_serial_add_sub;
`ifdef SERIAL_ADD_SUB_OVF_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   ntests;
    int   nfail;
    int   lat;
    int   bcnt;
    int   seen_done;
    logic [15:0] prev_sum;

    serial_add_sub_if #(.WIDTH(16)) bus0 ();
    serial_add_sub_if #(.WIDTH(16)) bus1 ();

    serial_add_sub #(.WIDTH(16), .DIGIT(4)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0.slave)
    );

    serial_add_sub #(.WIDTH(16), .DIGIT(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present a request at a negedge; it is sampled at the following posedge.
    task automatic start0(input logic [15:0] a, input logic [15:0] b,
                          input logic cin, input logic sub);
        bus0.a = a; bus0.b = b; bus0.cin = cin; bus0.sub = sub;
        bus0.start = 1'b1;
        @(negedge clk);
        bus0.start = 1'b0;
    endtask

    // Count cycles (from the START edge) until DONE, bounded.
    task automatic wait_done0(input int first, output int l, output int bc);
        l  = first;
        bc = 0;
        while (bus0.done !== 1'b1 && l < 40) begin
            if (bus0.busy === 1'b1) bc++;
            @(negedge clk);
            l++;
        end
    endtask

    task automatic op0(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic cin, input logic sub,
                       input logic [15:0] esum, input logic ecout, input logic eovf);
        int l, bc;
        start0(a, b, cin, sub);
        chk({tag, "_hold"}, {16'h0, bus0.sum}, {16'h0, prev_sum});
        wait_done0(1, l, bc);
        chk({tag, "_lat"},  l,  5);
        chk({tag, "_busy"}, bc, 4);
        chk({tag, "_sum"},  {16'h0, bus0.sum}, {16'h0, esum});
        chk({tag, "_cout"}, {31'h0, bus0.cout}, {31'h0, ecout});
        chk({tag, "_ovf"},  {31'h0, bus0.ovf},  {31'h0, eovf});
        chk({tag, "_dbusy"}, {31'h0, bus0.busy}, 32'h0);
        prev_sum = esum;
        @(negedge clk);
        chk({tag, "_pulse"}, {31'h0, bus0.done}, 32'h0);
    endtask

    initial begin
        ntests = 0; nfail = 0; prev_sum = 16'h0;
        bus0.start = 0; bus0.sub = 0; bus0.a = 0; bus0.b = 0; bus0.cin = 0;
        bus1.start = 0; bus1.sub = 0; bus1.a = 0; bus1.b = 0; bus1.cin = 0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'h0, bus0.busy}, 32'h0);
        chk("rst_done", {31'h0, bus0.done}, 32'h0);
        chk("rst_sum",  {16'h0, bus0.sum},  32'h0);
        chk("rst_cout", {31'h0, bus0.cout}, 32'h0);
        chk("rst_ovf",  {31'h0, bus0.ovf},  32'h0);
        chk("rst1_sum", {16'h0, bus1.sum},  32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        op0("add_basic", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
        op0("add_wrap",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        op0("add_cin",   16'hFFFF, 16'h0001, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b0);
        op0("add_ovf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, OVF_ON);
        op0("sub_ovf",   16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, OVF_ON);
        op0("sub_borrow",16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);

        // START during BUSY is dropped; START in the DONE cycle is taken.
        start0(16'h1111, 16'h2222, 1'b0, 1'b0);
        @(negedge clk);
        start0(16'h0F0F, 16'h0101, 1'b0, 1'b1);
        wait_done0(3, lat, bcnt);
        chk("ign_lat", lat, 5);
        chk("ign_sum", {16'h0, bus0.sum}, 32'h3333);
        start0(16'h0005, 16'h0003, 1'b0, 1'b0);
        wait_done0(1, lat, bcnt);
        chk("b2b_lat", lat, 5);
        chk("b2b_sum", {16'h0, bus0.sum}, 32'h0008);
        @(negedge clk);

        // DIGIT=1 instance: 16 RUN cycles, DONE 17 cycles after START.
        bus1.a = 16'h0005; bus1.b = 16'h0007; bus1.cin = 1'b0; bus1.sub = 1'b1;
        bus1.start = 1'b1;
        @(negedge clk);
        bus1.start = 1'b0;
        lat = 1;
        while (bus1.done !== 1'b1 && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        chk("d1_lat",  lat, 17);
        chk("d1_sum",  {16'h0, bus1.sum},  32'hFFFE);
        chk("d1_cout", {31'h0, bus1.cout}, 32'h0);
        @(negedge clk);

        // Reset mid-operation aborts and clears outputs at once.
        start0(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", {31'h0, bus0.busy}, 32'h0);
        chk("abort_done", {31'h0, bus0.done}, 32'h0);
        chk("abort_sum",  {16'h0, bus0.sum},  32'h0);
        chk("abort_cout", {31'h0, bus0.cout}, 32'h0);
        chk("abort_ovf",  {31'h0, bus0.ovf},  32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus0.done === 1'b1 || bus0.busy === 1'b1) seen_done++;
        end
        chk("abort_idle", seen_done, 0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
